aes_decrypt_sequencer: RTL and testbench

Control FSM that sequences the iterative AES-128 inverse-cipher datapath behind the Avalon AES register interface. It is started from the Start register (word 14). It then drives key-expansion enable, state-register load and source-select, round-key index and InvMixColumns word index in the standard decryption order. When the last round completes, it writes the result into the decrypted-message registers (words 8-11) and reports completion through the Done register (word 15).

---
 rtl/aes_decrypt_sequencer.sv | 135 +++++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_sequencer.sv
// Moore control FSM sequencing the iterative AES-128 inverse cipher datapath.
// Flow: IDLE > KEYEXP > LOAD > ARK(10) > 9 x {ISR, ISB, ARK, IMC x4} > ISR, ISB, ARK(0) > WB > DONE.
module aes_decrypt_sequencer #(
  parameter int KEY_EXP_CYCLES = 10,
  parameter int SBOX_LAT       = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEYEXP_EN,
  output logic       LD_STATE,
  output logic [1:0] STATE_SEL,
  output logic       SUB_SEL,
  output logic [3:0] ROUND_KEY_IDX,
  output logic [1:0] IMC_WORD,
  output logic       LD_DEC_MSG
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEYEXP, S_LOAD, S_ARK, S_ISR, S_ISB, S_IMC, S_WB, S_DONE
  } state_t;

  localparam logic [7:0] KEY_LAST  = 8'(KEY_EXP_CYCLES - 1);
  localparam logic [7:0] SBOX_LAST = 8'(SBOX_LAT - 1);

  state_t     state, state_n;
  logic [3:0] rc, rc_n;
  logic [7:0] cc, cc_n;
  logic [1:0] word, word_n;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      rc    <= '0;
      cc    <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      cc    <= cc_n;
      word  <= word_n;
    end
  end

  always_comb begin
    state_n       = state;
    rc_n          = rc;
    cc_n          = cc;
    word_n        = word;
    AES_DONE      = 1'b0;
    KEYEXP_EN     = 1'b0;
    LD_STATE      = 1'b0;
    STATE_SEL     = 2'd0;
    SUB_SEL       = 1'b0;
    ROUND_KEY_IDX = 4'd0;
    IMC_WORD      = 2'd0;
    LD_DEC_MSG    = 1'b0;
    BUSY          = (state != S_IDLE) && (state != S_DONE);

    case (state)
      S_IDLE: begin
        if (AES_START) begin
          state_n = S_KEYEXP;
          cc_n    = 8'd0;
        end
      end
      S_KEYEXP: begin
        KEYEXP_EN = 1'b1;
        if (cc == KEY_LAST) state_n = S_LOAD;
        else                cc_n    = cc + 8'd1;
      end
      S_LOAD: begin
        LD_STATE = 1'b1;
        state_n  = S_ARK;
        rc_n     = 4'd10;
      end
      S_ARK: begin
        LD_STATE      = 1'b1;
        STATE_SEL     = 2'd1;
        ROUND_KEY_IDX = rc;
        // Round 10 has no InvMixColumns; round 0 ends the pass before any decrement.
        if (rc == 4'd10) begin
          state_n = S_ISR;
          rc_n    = 4'd9;
        end else if (rc == 4'd0) begin
          state_n = S_WB;
        end else begin
          state_n = S_IMC;
          word_n  = 2'd0;
        end
      end
      S_ISR: begin
        LD_STATE  = 1'b1;
        STATE_SEL = 2'd2;
        state_n   = S_ISB;
        cc_n      = 8'd0;
      end
      S_ISB: begin
        STATE_SEL = 2'd2;
        SUB_SEL   = 1'b1;
        if (cc == SBOX_LAST) begin
          LD_STATE = 1'b1;
          state_n  = S_ARK;
        end else begin
          cc_n = cc + 8'd1;
        end
      end
      S_IMC: begin
        LD_STATE  = 1'b1;
        STATE_SEL = 2'd3;
        IMC_WORD  = word;
        word_n    = word + 2'd1;
        if (word == 2'd3) begin
          state_n = S_ISR;
          rc_n    = rc - 4'd1;
        end
      end
      S_WB: begin
        LD_DEC_MSG = 1'b1;
        state_n    = S_DONE;
      end
      S_DONE: begin
        AES_DONE = 1'b1;
        if (!AES_START) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A dropped start aborts any active pass, including the final ARK.
    if (BUSY && !AES_START) state_n = S_IDLE;
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: a schedule-table model of one pass checked every cycle
// on three parameterisations, plus directed timing, abort, reset and handshake checks.
module tb_aes_decrypt_sequencer;
  // {BUSY, KEYEXP_EN, LD_STATE, STATE_SEL, SUB_SEL, ROUND_KEY_IDX, IMC_WORD, LD_DEC_MSG, AES_DONE}
  typedef logic [13:0] vec_t;
  typedef vec_t vq_t[$];

  logic CLK = 1'b0;
  logic RESET;
  logic AES_START;
  always #5 CLK = ~CLK;

  logic [2:0] done_o, busy_o, kx_o, ld_o, sub_o, msg_o;
  logic [1:0] sel_o[3], imc_o[3];
  logic [3:0] rk_o[3];

  aes_decrypt_sequencer #(.KEY_EXP_CYCLES(10), .SBOX_LAT(1)) u0 (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DONE(done_o[0]), .BUSY(busy_o[0]),
    .KEYEXP_EN(kx_o[0]), .LD_STATE(ld_o[0]), .STATE_SEL(sel_o[0]), .SUB_SEL(sub_o[0]),
    .ROUND_KEY_IDX(rk_o[0]), .IMC_WORD(imc_o[0]), .LD_DEC_MSG(msg_o[0]));
  aes_decrypt_sequencer #(.KEY_EXP_CYCLES(1), .SBOX_LAT(1)) u1 (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DONE(done_o[1]), .BUSY(busy_o[1]),
    .KEYEXP_EN(kx_o[1]), .LD_STATE(ld_o[1]), .STATE_SEL(sel_o[1]), .SUB_SEL(sub_o[1]),
    .ROUND_KEY_IDX(rk_o[1]), .IMC_WORD(imc_o[1]), .LD_DEC_MSG(msg_o[1]));
  aes_decrypt_sequencer #(.KEY_EXP_CYCLES(20), .SBOX_LAT(3)) u2 (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DONE(done_o[2]), .BUSY(busy_o[2]),
    .KEYEXP_EN(kx_o[2]), .LD_STATE(ld_o[2]), .STATE_SEL(sel_o[2]), .SUB_SEL(sub_o[2]),
    .ROUND_KEY_IDX(rk_o[2]), .IMC_WORD(imc_o[2]), .LD_DEC_MSG(msg_o[2]));

  function automatic vec_t mk(int busy, int kx, int ld, int sel, int sub, int rk, int imc,
                              int msg, int done);
    return {1'(busy), 1'(kx), 1'(ld), 2'(sel), 1'(sub), 4'(rk), 2'(imc), 1'(msg), 1'(done)};
  endfunction

  // Every busy cycle of one uninterrupted pass, in order, ending with the write-back.
  function automatic vq_t build(int k, int l);
    vq_t q;
    q = {};
    for (int i = 0; i < k; i++) q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 1, 0, 10, 0, 0, 0));
    for (int r = 9; r >= 0; r--) begin
      q.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0));
      for (int c = 0; c < l; c++) q.push_back(mk(1, 0, (c == l - 1) ? 1 : 0, 2, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 1, 1, 0, r, 0, 0, 0));
      if (r != 0) for (int w = 0; w < 4; w++) q.push_back(mk(1, 0, 1, 3, 0, 0, w, 0, 0));
    end
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    return q;
  endfunction

  vq_t sched0, sched1, sched2;
  int  mode[3] = '{0, 0, 0};  // 0 idle, 1 running at idx, 2 done
  int  idx[3]  = '{0, 0, 0};

  function automatic int slen(int i);
    case (i)
      0: return sched0.size();
      1: return sched1.size();
      default: return sched2.size();
    endcase
  endfunction

  function automatic vec_t expv(int i);
    if (mode[i] == 2) return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (mode[i] == 1) begin
      case (i)
        0: return sched0[idx[i]];
        1: return sched1[idx[i]];
        default: return sched2[idx[i]];
      endcase
    end
    return '0;
  endfunction

  function automatic vec_t dutv(int i);
    return {busy_o[i], kx_o[i], ld_o[i], sel_o[i], sub_o[i], rk_o[i], imc_o[i], msg_o[i], done_o[i]};
  endfunction

  always @(posedge CLK or posedge RESET) begin
    for (int i = 0; i < 3; i++) begin
      if (RESET) begin
        mode[i] <= 0;
        idx[i]  <= 0;
      end else begin
        case (mode[i])
          0: if (AES_START) begin mode[i] <= 1; idx[i] <= 0; end
          1: begin
            if (!AES_START)               mode[i] <= 0;
            else if (idx[i] == slen(i) - 1) mode[i] <= 2;
            else                          idx[i]  <= idx[i] + 1;
          end
          default: if (!AES_START) mode[i] <= 0;
        endcase
      end
    end
  end

  int cyc = 0;
  int e_cyc = 0;
  int done_cyc[3] = '{-1, -1, -1};
  int msg_cyc = -1;
  int ld_cnt = 0;
  int msg_cnt = 0;
  int keys[$];
  logic [2:0] done_prev = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++)
      if (done_o[i] && !done_prev[i]) done_cyc[i] <= cyc;
    done_prev <= done_o;
    if (ld_o[0]) ld_cnt <= ld_cnt + 1;
    if (msg_o[0]) begin
      msg_cnt <= msg_cnt + 1;
      msg_cyc <= cyc;
    end
    if (ld_o[0] && sel_o[0] == 2'd1) keys.push_back(int'(rk_o[0]));
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int  base_ld, base_msg, base_key;
  bit  found;

  initial begin
    RESET = 1'b1;
    AES_START = 1'b0;
    sched0 = build(10, 1);
    sched1 = build(1, 1);
    sched2 = build(20, 3);
    // Pass length = cycles from E until DONE is entered.
    check("sched_len_k10_l1", 32'(sched0.size()), 32'd79);
    check("sched_len_k1_l1", 32'(sched1.size()), 32'd70);
    check("sched_len_k20_l3", 32'(sched2.size()), 32'd109);

    fork
      forever begin
        @(negedge CLK);
        for (int i = 0; i < 3; i++) check($sformatf("model_u%0d", i), 32'(dutv(i)), 32'(expv(i)));
      end
    join_none

    #2;
    check("reset_outputs_no_clock", 32'(dutv(0)), 32'd0);
    tick(2);
    RESET = 1'b0;
    tick(1);

    // Full pass on all three instances with start held past every DONE.
    base_ld = ld_cnt; base_msg = msg_cnt; base_key = keys.size();
    e_cyc = cyc + 1;
    AES_START = 1'b1;
    tick(121);
    check("done_edge_k10_l1", 32'(done_cyc[0] - e_cyc), 32'd79);
    check("done_edge_k1_l1", 32'(done_cyc[1] - e_cyc), 32'd70);
    check("done_edge_k20_l3", 32'(done_cyc[2] - e_cyc), 32'd109);
    check("wb_edge_k10_l1", 32'(msg_cyc - e_cyc), 32'd78);
    check("ld_state_pulses", 32'(ld_cnt - base_ld), 32'd68);
    check("ld_dec_msg_pulses", 32'(msg_cnt - base_msg), 32'd1);
    check("ark_key_count", 32'(keys.size() - base_key), 32'd11);
    if (keys.size() - base_key == 11)
      for (int j = 0; j < 11; j++) check("ark_key_order", 32'(keys[base_key + j]), 32'(10 - j));
    check("done_held", 32'(done_o), 32'h7);
    check("busy_in_done", 32'(busy_o), 32'h0);
    AES_START = 1'b0;
    tick(1);
    check("done_drop", 32'(done_o), 32'h0);

    // Asynchronous reset in the middle of IMC.
    tick(2);
    AES_START = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge CLK);
      if (sel_o[0] == 2'd3 && imc_o[0] == 2'd2) found = 1'b1;
    end
    check("imc_reached", 32'(found), 32'd1);
    #1 RESET = 1'b1;
    AES_START = 1'b0;
    #1;
    check("async_reset_u0", 32'(dutv(0)), 32'd0);
    check("async_reset_u2", 32'(dutv(2)), 32'd0);
    tick(1);
    RESET = 1'b0;
    tick(1);
    base_msg = msg_cnt;
    e_cyc = cyc + 1;
    AES_START = 1'b1;
    tick(82);
    check("post_reset_done_edge", 32'(done_cyc[0] - e_cyc), 32'd79);
    check("post_reset_msg", 32'(msg_cnt - base_msg), 32'd1);
    AES_START = 1'b0;
    tick(2);

    // Abort after E+40, then a clean restart.
    base_msg = msg_cnt;
    e_cyc = cyc + 1;
    AES_START = 1'b1;
    tick(41);
    AES_START = 1'b0;
    tick(1);
    check("abort_busy", 32'(busy_o), 32'h0);
    tick(80);
    check("abort_no_msg", 32'(msg_cnt - base_msg), 32'd0);
    check("abort_no_done", 32'(done_cyc[0] < e_cyc), 32'd1);
    base_msg = msg_cnt;
    e_cyc = cyc + 1;
    AES_START = 1'b1;
    tick(82);
    check("restart_done_edge", 32'(done_cyc[0] - e_cyc), 32'd79);
    check("restart_msg", 32'(msg_cnt - base_msg), 32'd1);
    AES_START = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
